// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: shared instruction/physical-register typedefs, default depth and wakeup helpers
package issue_queue_pkg;
  localparam int IQ_DEPTH_DEF = 8;
  localparam int PREG_W = 6;
  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] idx;
    logic              ready;
  } p_reg_t;
  typedef struct packed {
    logic              valid;
    logic [7:0]        op;
    logic [PREG_W-1:0] rd;
    p_reg_t            rs1;
    p_reg_t            rs2;
  } rinstr_t;
  // p0 is the hardwired zero register, so it never has to be waited on
  function automatic logic src_rdy(input p_reg_t s);
    return !s.valid || s.idx == '0 || s.ready;
  endfunction
  function automatic p_reg_t wake_src(input p_reg_t s, input p_reg_t c);
    wake_src = s;
    wake_src.ready = s.ready | (s.valid && c.valid && s.idx == c.idx);
  endfunction
  function automatic rinstr_t wake(input rinstr_t r, input p_reg_t c);
    wake = r;
    wake.rs1 = wake_src(r.rs1, c);
    wake.rs2 = wake_src(r.rs2, c);
  endfunction
endpackage

// File: rtl/issue_queue_select.sv
// iq_select: oldest-first (lowest index) pick among eligible queue slots
//   eligible_i: per-slot eligibility; grant_o: one-hot winner; idx_o: winner index; any_o: a winner exists
module iq_select #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  always_comb begin
    grant_o = eligible_i & (~eligible_i + N'(1));
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) if (eligible_i[i]) idx_o = IW'(i);
    any_o = |eligible_i;
  end
endmodule

// File: rtl/issue_queue.sv
// issue_queue: age-ordered collapsing issue queue with wakeup and oldest-ready issue
//   clk_i/rst_ni: clock, async active-low reset; rinstr_i: enqueue; p_commit_i: wakeup broadcast
//   flush_i: drop everything; issue_ready_i: downstream accepts issue_o; iq_full_o: no free slot
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int IQ_DEPTH = IQ_DEPTH_DEF
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  rinstr_t rinstr_i,
  input  p_reg_t  p_commit_i,
  input  logic    flush_i,
  input  logic    issue_ready_i,
  output rinstr_t issue_o,
  output logic    iq_full_o
);
  localparam int IW = $clog2(IQ_DEPTH);
  localparam int CW = IW + 1;
  rinstr_t ent_q [IQ_DEPTH];
  rinstr_t ent_d [IQ_DEPTH];
  rinstr_t shift [IQ_DEPTH+1];
  logic [CW-1:0] count_q, count_d, base;
  logic [IQ_DEPTH-1:0] elig, grant;
  logic [IW-1:0] sel_idx;
  logic sel_any, do_iss, do_enq;
  // eligibility uses stored ready bits only, so a wakeup shows up one cycle later
  always_comb begin
    elig = '0;
    for (int i = 0; i < IQ_DEPTH; i++)
      elig[i] = CW'(i) < count_q && src_rdy(ent_q[i].rs1) && src_rdy(ent_q[i].rs2);
  end
  iq_select #(.N(IQ_DEPTH)) u_sel (
    .eligible_i(elig),
    .grant_o   (grant),
    .idx_o     (sel_idx),
    .any_o     (sel_any)
  );
  always_comb begin
    issue_o = '0;
    if (!flush_i) for (int i = 0; i < IQ_DEPTH; i++) if (grant[i]) issue_o = ent_q[i];
    issue_o.valid = sel_any && !flush_i;
  end
  assign iq_full_o = count_q == CW'(IQ_DEPTH);
  // wake first, then collapse over the issued slot, then append at the post-collapse tail
  always_comb begin
    do_iss = issue_o.valid && issue_ready_i;
    do_enq = rinstr_i.valid && !iq_full_o && !flush_i;
    base = count_q - CW'(do_iss);
    shift[IQ_DEPTH] = '0;
    for (int i = 0; i < IQ_DEPTH; i++) shift[i] = wake(ent_q[i], p_commit_i);
    for (int i = 0; i < IQ_DEPTH; i++) begin
      ent_d[i] = (do_iss && CW'(i) >= CW'(sel_idx)) ? shift[i+1] : shift[i];
      if (do_enq && CW'(i) == base) ent_d[i] = wake(rinstr_i, p_commit_i);
      if (flush_i) ent_d[i] = '0;
    end
    count_d = flush_i ? '0 : base + CW'(do_enq);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < IQ_DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed stimulus with a scoreboard of expected issue order and a decoupled monitor
module tb_issue_queue;
  import issue_queue_pkg::*;
  logic clk_i = 1'b0;
  logic rst_ni, flush_i, issue_ready_i, iq_full_o;
  rinstr_t rinstr_i, issue_o, mon_e, ex, e0;
  p_reg_t p_commit_i;
  int checks = 0;
  int errors = 0;
  rinstr_t exp_q[$];
  always #5 clk_i = ~clk_i;
  issue_queue #(.IQ_DEPTH(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rinstr_i     (rinstr_i),
    .p_commit_i   (p_commit_i),
    .flush_i      (flush_i),
    .issue_ready_i(issue_ready_i),
    .issue_o      (issue_o),
    .iq_full_o    (iq_full_o)
  );
  function automatic p_reg_t pr(input logic v, input int idx, input logic r);
    pr.valid = v;
    pr.idx = 6'(idx);
    pr.ready = r;
  endfunction
  function automatic rinstr_t mk(input int op, input p_reg_t s1, input p_reg_t s2);
    mk.valid = 1'b1;
    mk.op = 8'(op);
    mk.rd = 6'(op);
    mk.rs1 = s1;
    mk.rs2 = s2;
  endfunction
  task automatic chk(input string n, input rinstr_t a, input rinstr_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic chkb(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
    rinstr_i = '0;
    p_commit_i = '0;
    flush_i = 1'b0;
  endtask
  always @(negedge clk_i) begin
    if (rst_ni && issue_o.valid && issue_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got %h expected none", issue_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (issue_o !== mon_e) begin
          errors++;
          $display("FAIL issue_order: got %h expected %h", issue_o, mon_e);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_ni = 1'b0;
    rinstr_i = '0;
    p_commit_i = '0;
    flush_i = 1'b0;
    issue_ready_i = 1'b0;
    #2;
    chk("reset_issue", issue_o, '0);
    chkb("reset_full", iq_full_o, 1'b0);
    #20 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    issue_ready_i = 1'b1;
    exp_q.push_back(mk(1, pr(1, 40, 1), pr(0, 0, 0)));
    rinstr_i = mk(1, pr(1, 40, 0), pr(0, 0, 0));
    tick();
    chkb("t1_not_ready", issue_o.valid, 1'b0);
    p_commit_i = pr(1, 40, 0);
    #1 chkb("t1_no_bypass", issue_o.valid, 1'b0);
    tick();
    chkb("t1_woken", issue_o.valid, 1'b1);
    tick();
    chkb("t1_drained", issue_o.valid, 1'b0);
    issue_ready_i = 1'b0;
    e0 = mk(16, pr(0, 0, 0), pr(1, 33, 1));
    for (int k = 0; k < 8; k++) begin
      ex = mk(16 + k, pr(k[0], 0, 0), pr(1, 33, 1));
      exp_q.push_back(ex);
      rinstr_i = ex;
      tick();
      chkb("t2_full", iq_full_o, k == 7);
    end
    chk("t2_head", issue_o, e0);
    rinstr_i = mk(99, pr(0, 0, 0), pr(0, 0, 0));
    tick();
    chkb("t2_still_full", iq_full_o, 1'b1);
    chk("t2_hold_head", issue_o, e0);
    issue_ready_i = 1'b1;
    tick();
    chkb("t2_count7", iq_full_o, 1'b0);
    ex = mk(40, pr(0, 0, 0), pr(0, 0, 0));
    exp_q.push_back(ex);
    rinstr_i = ex;
    tick();
    chkb("t2_enq_and_issue", iq_full_o, 1'b0);
    issue_ready_i = 1'b0;
    ex = mk(41, pr(1, 0, 0), pr(0, 0, 0));
    exp_q.push_back(ex);
    rinstr_i = ex;
    tick();
    chkb("t2_refull", iq_full_o, 1'b1);
    issue_ready_i = 1'b1;
    repeat (8) tick();
    chkb("t2_empty", issue_o.valid, 1'b0);
    chkb("t2_not_full", iq_full_o, 1'b0);
    issue_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ex = mk(80 + k, pr(1, 0, 1), pr(0, 5, 0));
      exp_q.push_back(ex);
      rinstr_i = ex;
      tick();
    end
    issue_ready_i = 1'b1;
    chk("t3_first", issue_o, mk(80, pr(1, 0, 1), pr(0, 5, 0)));
    tick();
    chk("t3_second", issue_o, mk(81, pr(1, 0, 1), pr(0, 5, 0)));
    tick();
    chk("t3_third", issue_o, mk(82, pr(1, 0, 1), pr(0, 5, 0)));
    tick();
    chkb("t3_empty", issue_o.valid, 1'b0);
    issue_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rinstr_i = mk(96 + k, pr(0, 0, 0), pr(0, 0, 0));
      tick();
    end
    rinstr_i = mk(112, pr(0, 0, 0), pr(0, 0, 0));
    flush_i = 1'b1;
    #1 chk("t4_flush_out", issue_o, '0);
    tick();
    chkb("t4_valid0", issue_o.valid, 1'b0);
    ex = mk(113, pr(0, 0, 0), pr(0, 0, 0));
    exp_q.push_back(ex);
    rinstr_i = ex;
    tick();
    chk("t4_fresh_head", issue_o, ex);
    issue_ready_i = 1'b1;
    tick();
    chkb("t4_empty", issue_o.valid, 1'b0);
    issue_ready_i = 1'b0;
    exp_q.push_back(mk(128, pr(1, 45, 1), pr(1, 0, 0)));
    rinstr_i = mk(128, pr(1, 45, 0), pr(1, 0, 0));
    p_commit_i = pr(1, 45, 0);
    tick();
    chk("t5_woken_enq", issue_o, mk(128, pr(1, 45, 1), pr(1, 0, 0)));
    issue_ready_i = 1'b1;
    tick();
    chkb("t5_empty", issue_o.valid, 1'b0);
    rinstr_i = mk(144, pr(1, 50, 0), pr(1, 51, 1));
    tick();
    chkb("t6_blocked", issue_o.valid, 1'b0);
    exp_q.push_back(mk(145, pr(0, 0, 0), pr(1, 0, 0)));
    exp_q.push_back(mk(144, pr(1, 50, 1), pr(1, 51, 1)));
    rinstr_i = mk(145, pr(0, 0, 0), pr(1, 0, 0));
    tick();
    chk("t6_younger_first", issue_o, mk(145, pr(0, 0, 0), pr(1, 0, 0)));
    p_commit_i = pr(1, 50, 0);
    tick();
    chk("t6_older_after_wake", issue_o, mk(144, pr(1, 50, 1), pr(1, 51, 1)));
    tick();
    chkb("t6_empty", issue_o.valid, 1'b0);
    issue_ready_i = 1'b0;
    rinstr_i = mk(160, pr(0, 0, 0), pr(0, 0, 0));
    tick();
    rinstr_i = mk(161, pr(0, 0, 0), pr(0, 0, 0));
    tick();
    #2 rst_ni = 1'b0;
    #1 chk("t7_reset_out", issue_o, '0);
    chkb("t7_reset_full", iq_full_o, 1'b0);
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tick();
    chkb("t7_no_survivor", issue_o.valid, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 8, meaning number of queue entries (power of two, >=2).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port rinstr_i  input  rinstr_t  renamed instruction from rename stage; .valid qualifies it.
REQ-005 SHALL have port p_commit_i  input  p_reg_t  wakeup broadcast; .valid with .idx marks physical register produced.
REQ-006 SHALL have port flush_i  input  1  branch-mispredict flush (driven from br_result_t valid && !hit).
REQ-007 SHALL have port issue_ready_i  input  1  downstream execute accepts issue_o this cycle.
REQ-008 SHALL have port issue_o  output  rinstr_t  selected ready instruction; .valid qualifies it.
REQ-009 SHALL have port iq_full_o  output  1  no free entry; upstream must hold rinstr_i.

Function
REQ-010 SHALL store entries in age order, slot 0 oldest, with occupancy counter count (0..IQ_DEPTH).
REQ-011 SHALL assert iq_full_o combinationally iff count == IQ_DEPTH, independent of a same-cycle issue.
REQ-012 SHALL enqueue rinstr_i at slot count (after collapse) when rinstr_i.valid && !iq_full_o && !flush_i.
REQ-013 SHALL drop rinstr_i silently when iq_full_o or flush_i is high.
REQ-014 SHALL treat a source as ready when its .valid is 0, or its .idx is 0, or its stored .ready is 1.
REQ-015 SHALL mark an entry eligible when all its sources are ready per REQ-014.
REQ-016 SHALL drive issue_o with the lowest-index (oldest) eligible entry, issue_o.valid = 1, all fields unmodified except ready bits.
REQ-017 SHALL drive issue_o = '0 when no entry is eligible or flush_i is high.
REQ-018 SHALL complete an issue when issue_o.valid && issue_ready_i; that entry is removed at the next edge and all younger entries shift down one slot.
REQ-019 SHALL hold issue_o stable (same entry) while issue_ready_i is low unless an older entry becomes eligible.
REQ-020 SHALL, when p_commit_i.valid, set .ready on every stored source with matching .idx at the next edge.
REQ-021 SHALL apply the same wakeup to rinstr_i sources being enqueued in that cycle.
REQ-022 SHALL make woken entries eligible no earlier than the cycle after the wakeup (no same-cycle bypass to issue_o).
REQ-023 SHALL give minimum latency enqueue to issue_o.valid of one cycle.
REQ-024 SHALL handle simultaneous enqueue and issue: count unchanged, new entry lands at slot count-1 after collapse.
REQ-025 SHALL allow enqueue in the cycle count == IQ_DEPTH-1 and then assert iq_full_o the next cycle.
REQ-026 SHALL, on flush_i, invalidate all entries and set count = 0 at the next edge; flush overrides enqueue, issue and wakeup.

Reset
REQ-027 SHALL, while rst_ni is low, clear all entries, count = 0, giving issue_o = '0 and iq_full_o = 0.
REQ-028 SHALL discard in-flight entries when reset asserts mid-operation; no entry survives reset.

Structure
REQ-029 SHALL take rinstr_t and p_reg_t from the shared typedefs package; IQ_DEPTH default belongs there as a localparam constant.
REQ-030 SHALL implement oldest-eligible selection in one sub-module iq_select (eligible vector in, one-hot grant and index out, combinational).
REQ-031 SHALL keep entry storage, wakeup, collapse and count in issue_queue; fit in 120-400 RTL lines.

Verification
REQ-032 Enqueue op with rs1 p40 not ready, rs2 invalid; p_commit_i p40 next cycle -> issue_o.valid exactly one cycle after wakeup, rs1.ready = 1.
REQ-033 Fill 8 entries all sources ready, issue_ready_i = 0 -> iq_full_o = 1, 9th rinstr_i dropped, issue_o = slot 0 entry.
REQ-034 Three ready entries A,B,C, issue_ready_i = 1 -> issued A,B,C in order on consecutive cycles, count 3->0.
REQ-035 Full queue, enqueue and issue same cycle while iq_full_o = 0 at count 7 -> count stays 7, order preserved.
REQ-036 Five entries plus valid rinstr_i with flush_i = 1 -> next cycle count = 0, issue_o.valid = 0, rinstr_i not stored.
REQ-037 Wakeup p45 coincident with enqueue of entry sourcing p45 -> entry enqueued with ready set, issues next cycle.
